// File: rtl/fir_feed_ctrl.sv
// Read-side feeder: drains the sample FIFO one word at a time into the FIR core over valid/ready.
// Optional statistics counters (sample_cnt, stall_cnt) are built when FIR_FEED_STATS_EN is defined.
module fir_feed_ctrl #(
    parameter int DATA_W    = 16,
    parameter int BLOCK_LEN = 8
) (
    input  logic              clk_rd,
    input  logic              rst,
    input  logic              run,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic [DATA_W-1:0] fir_data,
    output logic              fir_valid,
    input  logic              fir_ready,
    output logic              block_done,
    output logic              busy
`ifdef FIR_FEED_STATS_EN
    ,
    output logic [31:0]       sample_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int IDX_W = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [DATA_W-1:0] fir_data_reg;
    logic [IDX_W-1:0]  blk_idx_reg;
    logic              block_done_reg;
    logic              rd_en;
    logic              handshake;

    assign fir_valid  = (state_reg == PRESENT);
    assign handshake  = fir_valid && fir_ready;
    assign busy       = (state_reg != IDLE);
    assign fir_data   = fir_data_reg;
    assign block_done = block_done_reg;
    assign fifo_rd_en = rd_en;

    // At most one read is ever in flight: new reads only leave IDLE or a completing PRESENT.
    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (run && !fifo_empty) begin
                    rd_en      = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = PRESENT;
            end
            PRESENT: begin
                if (fir_ready) begin
                    if (run && !fifo_empty) begin
                        rd_en      = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            rd_en = 1'b0;
        end
    end

    always_ff @(posedge clk_rd) begin
        if (rst) begin
            state_reg      <= IDLE;
            fir_data_reg   <= '0;
            blk_idx_reg    <= '0;
            block_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            block_done_reg <= 1'b0;
            if (state_reg == FETCH) begin
                fir_data_reg <= fifo_rd_data;
            end
            if (handshake) begin
                if (blk_idx_reg == IDX_LAST) begin
                    blk_idx_reg    <= '0;
                    block_done_reg <= 1'b1;
                end else begin
                    blk_idx_reg <= blk_idx_reg + 1'b1;
                end
            end
        end
    end

`ifdef FIR_FEED_STATS_EN
    logic [31:0] sample_cnt_reg;
    logic [15:0] stall_cnt_reg;

    assign sample_cnt = sample_cnt_reg;
    assign stall_cnt  = stall_cnt_reg;

    always_ff @(posedge clk_rd) begin
        if (rst) begin
            sample_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            if (handshake) begin
                sample_cnt_reg <= sample_cnt_reg + 32'd1;
            end
            // Stall count saturates so a long backpressure episode cannot alias to a small value.
            if (fir_valid && !fir_ready && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fir_feed_ctrl.sv
// Scoreboard bench for fir_feed_ctrl: a FIFO model feeds the DUT, a monitor checks every cycle.
// Statistic port checks are compiled in only when FIR_FEED_STATS_EN is defined.
module tb_fir_feed_ctrl;

    localparam int DATA_W    = 16;
    localparam int BLOCK_LEN = 8;

    logic              clk_rd = 1'b0;
    logic              rst;
    logic              run;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic [DATA_W-1:0] fir_data;
    logic              fir_valid;
    logic              fir_ready;
    logic              block_done;
    logic              busy;
`ifdef FIR_FEED_STATS_EN
    logic [31:0]       sample_cnt;
    logic [15:0]       stall_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int hs_num = 0;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];

    always #5 clk_rd = ~clk_rd;

    fir_feed_ctrl #(
        .DATA_W   (DATA_W),
        .BLOCK_LEN(BLOCK_LEN)
    ) dut (
        .clk_rd      (clk_rd),
        .rst         (rst),
        .run         (run),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fir_data    (fir_data),
        .fir_valid   (fir_valid),
        .fir_ready   (fir_ready),
        .block_done  (block_done),
        .busy        (busy)
`ifdef FIR_FEED_STATS_EN
        ,
        .sample_cnt  (sample_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        fifo_q.push_back(v);
        fifo_empty = 1'b0;
    endtask

    // One clock: the FIFO model answers a read with data valid in the following cycle.
    task automatic tick();
        logic rd;
        logic [DATA_W-1:0] v;
        #1 rd = fifo_rd_en;
        @(posedge clk_rd);
        #1;
        if (rd && fifo_q.size() > 0) begin
            v = fifo_q.pop_front();
            fifo_rd_data = v;
            exp_q.push_back(v);
        end else begin
            fifo_rd_data = DATA_W'($urandom);
        end
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk_rd);
    endtask

    // Monitor: reference model of the feeder in terms of outstanding samples and handshake counts.
    initial begin
        logic              outst = 1'b0;
        int                age = 0;
        int                blk = 0;
        logic              exp_bd = 1'b0;
        logic              prev_hold = 1'b0;
        logic [DATA_W-1:0] prev_data = '0;
        logic              exp_valid;
        logic              exp_rd;
        logic              hs;
        logic [DATA_W-1:0] want;
        longint            m_samp = 0;
        int                m_stall = 0;
        forever begin
            @(negedge clk_rd);
            #3;
            exp_valid = outst && (age >= 1);
            hs        = exp_valid && fir_ready;
            exp_rd    = !rst && run && !fifo_empty && (!outst || hs);
            chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
            if (fifo_rd_en && fifo_empty) begin
                chk("rd_while_empty", 32'(fifo_rd_en), 32'd0);
            end
            chk("fir_valid", 32'(fir_valid), 32'(exp_valid));
            chk("busy", 32'(busy), 32'(outst));
            chk("block_done", 32'(block_done), 32'(exp_bd));
`ifdef FIR_FEED_STATS_EN
            chk("sample_cnt", sample_cnt, m_samp[31:0]);
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
            if (prev_hold && exp_valid) begin
                chk("data_stable", 32'(fir_data), 32'(prev_data));
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    want = exp_q.pop_front();
                    chk("fir_data", 32'(fir_data), 32'(want));
                    hs_num++;
                    $display("hs %0d data=%04h blk_idx=%0d t=%0t", hs_num, fir_data, blk, $time);
                end
            end
            prev_hold = exp_valid && !fir_ready && !rst;
            prev_data = fir_data;
            if (rst) begin
                outst   = 1'b0;
                age     = 0;
                blk     = 0;
                exp_bd  = 1'b0;
                m_samp  = 0;
                m_stall = 0;
                exp_q.delete();
                prev_hold = 1'b0;
            end else begin
                exp_bd = hs && (blk == BLOCK_LEN - 1);
                if (hs) begin
                    blk   = (blk + 1) % BLOCK_LEN;
                    outst = 1'b0;
                    m_samp++;
                end
                if (exp_valid && !fir_ready && m_stall != 16'hFFFF) begin
                    m_stall++;
                end
                if (outst) begin
                    age++;
                end
                if (exp_rd) begin
                    outst = 1'b1;
                    age   = 0;
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized soak.
    initial begin
        rst          = 1'b1;
        run          = 1'b1;
        fir_ready    = 1'b1;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        @(negedge clk_rd);
        for (int i = 1; i <= 16; i++) begin
            push(DATA_W'(i));
        end
        repeat (4) tick();
        rst = 1'b0;
        repeat (40) tick();

        push(16'h00A5);
        fir_ready = 1'b0;
        repeat (7) tick();
        fir_ready = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 3; i++) begin
            push(DATA_W'($urandom));
        end
        repeat (12) tick();
        push(16'h1234);
        push(16'h5678);
        repeat (10) tick();

        run = 1'b0;
        repeat (2) tick();
        push(16'h0011);
        push(16'h0022);
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (6) tick();
        run = 1'b1;
        repeat (8) tick();

        for (int i = 0; i < 20; i++) begin
            push(DATA_W'(16'h0100 + i));
        end
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (40) tick();

        for (int i = 0; i < 800; i++) begin
            run       = ($urandom_range(0, 9) != 0);
            fir_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 149) == 0);
            if (($urandom_range(0, 2) == 0) && fifo_q.size() < 8) begin
                push(DATA_W'($urandom));
            end
            tick();
        end

        rst       = 1'b0;
        run       = 1'b1;
        fir_ready = 1'b1;
        repeat (80) tick();
        chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        chk("drain_fifo", 32'(fifo_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_feed_ctrl.md
# fir_feed_ctrl

Read-side controller that drains the input sample FIFO and feeds the FIR core one sample at a time. Runs in the FIFO read clock domain: it issues FIFO read strobes, captures the read data, and holds it on a valid/ready handshake until the FIR core accepts it. It groups accepted samples into blocks of fixed length and flags each completed block.

## Interface
Parameters:
- DATA_W, 16, sample width; matches FIFO data width
- BLOCK_LEN, 8, samples per block (≥2)

Ports:
- clk_rd  in  1  read-domain clock; sole clock of the block
- rst  in  1  synchronous, active-high reset
- run  in  1  enable draining; level-sensitive
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read strobe
- fifo_rd_data  in  DATA_W  FIFO read data; valid the cycle after fifo_rd_en
- fir_data  out  DATA_W  sample to FIR core
- fir_valid  out  1  fir_data valid
- fir_ready  in  1  FIR core accepts sample
- block_done  out  1  one-cycle pulse per completed block
- busy  out  1  high whenever state ≠ IDLE
- sample_cnt  out  32  accepted samples (FIR_FEED_STATS_EN only)
- stall_cnt  out  16  stall cycles (FIR_FEED_STATS_EN only)

## Operation
- States: IDLE, FETCH, PRESENT.
- IDLE: fifo_rd_en = run && !fifo_empty; when high → FETCH.
- FETCH: fifo_rd_en = 0; fir_data ← fifo_rd_data at end of cycle; → PRESENT.
- PRESENT: fir_valid = 1, fir_data held stable. Handshake = fir_valid && fir_ready.
  - Handshake with run && !fifo_empty: fifo_rd_en = 1 in same cycle, → FETCH (back-to-back).
  - Handshake otherwise: → IDLE.
  - No handshake: stay; fifo_rd_en = 0.
- fifo_rd_en is a Mealy decode of state, run, fifo_empty, fir_ready; forced 0 while rst high.
- Never more than one outstanding FIFO read; fifo_rd_en never asserted while fifo_empty.
- Block index 0..BLOCK_LEN-1 increments on each handshake; handshake at index BLOCK_LEN-1 wraps index to 0 and sets block_done high for the following cycle only.
- run deassertion never aborts: a sample in FETCH or PRESENT is still delivered; controller then parks in IDLE. Block index retained across run low.

## Timing
- Reset values: fifo_rd_en 0, fir_valid 0, fir_data 0, block_done 0, busy 0, state IDLE, block index 0, sample_cnt 0, stall_cnt 0.
- rst mid-operation: next cycle all of the above; sample in flight is dropped (not re-read).
- Latency: fifo_rd_en at cycle N → fir_valid high from N+2.
- Peak throughput: one sample per 2 cycles with fir_ready held high and FIFO non-empty.
- block_done: cycle after the BLOCK_LEN-th handshake.
- fifo_empty sampled only in cycles where fifo_rd_en is decoded; going empty while in FETCH/PRESENT has no effect on the current sample.

## Configuration
- FIR_FEED_STATS_EN defined: sample_cnt increments on every handshake, wraps at 2^32; stall_cnt increments each PRESENT cycle with fir_ready low, saturates at 16'hFFFF. Both cleared only by rst.
- Not defined: sample_cnt and stall_cnt ports and logic absent; all other behaviour identical.

## Test plan
- Reset: assert rst with run=1, fifo_empty=0 → fifo_rd_en=0, fir_valid=0, busy=0 throughout rst; first fifo_rd_en the cycle after rst falls.
- Streaming: FIFO preloaded 1..16, run=1, fir_ready=1 → fir_data sequence 1..16, one handshake every 2 cycles, block_done pulses after samples 8 and 16; sample_cnt=16, stall_cnt=0 (stats on).
- Backpressure: fir_ready low 5 cycles while presenting sample 0x00A5 → fir_data stable at 0x00A5, fir_valid held, no fifo_rd_en, stall_cnt=5.
- Empty/underrun: FIFO holds 3 samples, run=1 → 3 handshakes, then IDLE, busy=0, fifo_rd_en never high with fifo_empty=1; new write resumes draining.
- run drop: deassert run in FETCH cycle → that sample still presented and accepted, then IDLE with no further reads; block index resumes from 1 on next run.
- Mid-run reset: rst during PRESENT at block index 5 → next cycle fir_valid=0, index 0; next block_done only after 8 further handshakes.
